// File: rtl/fetch_unit.sv
// fetch_unit: PC keeper issuing credit-limited imem reads, buffering in-order responses for decode with stall, flush and branch redirect
module fetch_unit #(
  parameter int PC_W = 16,
  parameter int INSTR_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               stall,
  input  logic               flush,
  input  logic               is_branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int PW = $clog2(BUF_DEPTH);
  typedef enum logic [1:0] {HOLD, RUN, SQUASH} state_t;
  state_t state;
  logic [PC_W-1:0] fetch_pc, rsp_pc;
  logic [PC_W-1:0] fifo_pc [BUF_DEPTH];
  logic [INSTR_W-1:0] fifo_data [BUF_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, in_flight, drop_cnt, drop_nx;
  logic [CW1-1:0] credits;
  logic redirect, empty, pop, drop, push, req_fire;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(BUF_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign redirect = flush | is_branch_taken;
  assign empty = count == '0;
  assign pop = !empty && !stall && !redirect;
  assign drop = imem_rsp_valid && drop_cnt != '0;
  assign push = imem_rsp_valid && !drop && !redirect;
  assign credits = CW1'(in_flight) + CW1'(count) - CW1'(pop);
  assign imem_req_valid = state != HOLD && !redirect && credits < CW1'(BUF_DEPTH);
  assign req_fire = imem_req_valid && imem_req_ready;
  assign drop_nx = redirect ? in_flight - CW'(imem_rsp_valid) : drop_cnt - CW'(drop);
  assign imem_req_addr = fetch_pc;
  assign instr_valid = !empty;
  assign instr = empty ? '0 : fifo_data[rd_ptr];
  assign instr_pc = empty ? '0 : fifo_pc[rd_ptr];
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= HOLD;
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      in_flight <= '0;
      drop_cnt <= '0;
    end else begin
      state <= (state != HOLD && drop_nx != '0) ? SQUASH : RUN;
      in_flight <= in_flight + CW'(req_fire) - CW'(imem_rsp_valid);
      drop_cnt <= drop_nx;
      fetch_pc <= redirect ? branch_target : fetch_pc + PC_W'(req_fire);
      rsp_pc <= redirect ? branch_target : rsp_pc + PC_W'(push);
      rd_ptr <= redirect ? '0 : pop ? inc(rd_ptr) : rd_ptr;
      wr_ptr <= redirect ? '0 : push ? inc(wr_ptr) : wr_ptr;
      count <= redirect ? '0 : count + CW'(push) - CW'(pop);
      if (push) begin
        fifo_pc[wr_ptr] <= rsp_pc;
        fifo_data[wr_ptr] <= imem_rsp_data;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard and vector-table bench for fetch_unit with an in-order variable-latency memory model
module tb_fetch_unit;
  localparam logic [15:0] RP = 16'hFFFE;
  logic clk = 0;
  logic reset, imem_req_valid, imem_req_ready, imem_rsp_valid, stall, flush, is_branch_taken, instr_valid;
  logic [15:0] imem_req_addr, imem_rsp_data, branch_target, instr, instr_pc;
  typedef struct {int due; logic [15:0] data;} mrsp_t;
  typedef struct {logic [15:0] pc; logic [15:0] ins;} exp_t;
  typedef struct {int lat; logic fl; logic st; logic [15:0] tgt; logic [15:0] ins;} vec_t;
  mrsp_t mq[$];
  exp_t sb[$];
  vec_t vt[4];
  int n_chk = 0, n_fail = 0, cyc = 0, lat = 1, consumed = 0;
  logic [15:0] next_addr = RP, p_instr = 0, p_pc = 0, pc0;
  logic p_hold = 0, redir;
  exp_t e;
  int c0;

  fetch_unit #(.RESET_PC(RP)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .flush(flush), .is_branch_taken(is_branch_taken), .branch_target(branch_target),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always begin
    @(posedge clk);
    cyc++;
    redir = flush || is_branch_taken;
    if (p_hold) begin
      chk("hold_valid", instr_valid, 1);
      chk("hold_instr", instr, p_instr);
      chk("hold_pc", instr_pc, p_pc);
    end
    p_hold = reset && stall && !redir && instr_valid;
    p_instr = instr;
    p_pc = instr_pc;
    if (!reset) begin
      mq.delete();
      sb.delete();
      next_addr = RP;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, next_addr);
        chk("req_in_redirect", redir, 0);
        mq.push_back('{cyc + lat - 1, imem_req_addr ^ 16'hA500});
        sb.push_back('{next_addr, next_addr ^ 16'hA500});
        next_addr = next_addr + 16'd1;
      end
      if (instr_valid && !stall && !redir) begin
        consumed++;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_instr: got pc %h with nothing outstanding", instr_pc);
        end else begin
          e = sb.pop_front();
          chk("instr_pc", instr_pc, e.pc);
          chk("instr", instr, e.ins);
        end
      end
      if (redir) begin
        sb.delete();
        next_addr = branch_target;
      end
    end
    #1;
    imem_rsp_valid = 0;
    if (reset && mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1;
      imem_rsp_data = mq[0].data;
      void'(mq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    vt[0] = '{3, 1'b0, 1'b0, 16'h0008, 16'hA508};
    vt[1] = '{1, 1'b1, 1'b1, 16'h0100, 16'hA400};
    vt[2] = '{2, 1'b1, 1'b0, 16'hFFFF, 16'h5AFF};
    vt[3] = '{3, 1'b0, 1'b1, 16'h1234, 16'hB734};
    reset = 0; imem_req_ready = 1; stall = 0; flush = 0; is_branch_taken = 0;
    branch_target = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, RP);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_instr_valid", instr_valid, 0);
    reset = 1;
    repeat (2) @(negedge clk);
    chk("early_valid", instr_valid, 0);
    @(negedge clk);
    chk("first_valid", instr_valid, 1);
    chk("first_pc", instr_pc, RP);
    chk("first_instr", instr, RP ^ 16'hA500);
    c0 = consumed;
    repeat (10) @(negedge clk);
    chk("throughput", consumed - c0, 10);
    chk("wrapped_pc", instr_pc, 16'h0008);
    stall = 1;
    pc0 = instr_pc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_pc", instr_pc, pc0);
      if (i >= 2) chk("stall_req_low", imem_req_valid, 0);
    end
    stall = 0;
    c0 = consumed;
    repeat (8) @(negedge clk);
    chk("after_stall_count", consumed - c0, 8);
    for (int v = 0; v < 4; v++) begin
      lat = vt[v].lat;
      repeat (6) @(negedge clk);
      stall = vt[v].st;
      flush = vt[v].fl;
      is_branch_taken = !vt[v].fl;
      branch_target = vt[v].tgt;
      #1;
      chk("redirect_no_req", imem_req_valid, 0);
      @(negedge clk);
      stall = 0; flush = 0; is_branch_taken = 0;
      chk("redirect_invalid", instr_valid, 0);
      chk("redirect_nop", instr, 0);
      for (int t = 0; t < 20 && !instr_valid; t++) @(negedge clk);
      chk("redirect_valid", instr_valid, 1);
      chk("redirect_pc", instr_pc, vt[v].tgt);
      chk("redirect_instr", instr, vt[v].ins);
    end
    lat = 2;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      imem_req_ready = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 3) == 0;
    end
    c0 = consumed;
    chk("random_progress", consumed > 10, 1);
    reset = 0; imem_req_ready = 1; stall = 0;
    @(negedge clk);
    chk("midrst_req_valid", imem_req_valid, 0);
    chk("midrst_req_addr", imem_req_addr, RP);
    chk("midrst_instr", instr, 0);
    chk("midrst_instr_pc", instr_pc, 0);
    chk("midrst_valid", instr_valid, 0);
    @(negedge clk);
    reset = 1;
    for (int t = 0; t < 10 && !instr_valid; t++) @(negedge clk);
    chk("post_rst_valid", instr_valid, 1);
    chk("post_rst_pc", instr_pc, RP);
    chk("post_rst_instr", instr, RP ^ 16'hA500);
    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
